// File: rtl/uart_apb_regfile.sv
// UART APB register file: TX/RX FIFOs, baud divisor, frame config,
// live status and sticky W1C interrupt flags.
module uart_apb_regfile #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              pSel,
  input  logic              pEnable,
  input  logic              pWrite,
  input  logic [31:0]       pAddr,
  input  logic [31:0]       pWdata,
  output logic [31:0]       pRData,
  output logic              pSlvErr,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              tx_done,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_fe,
  input  logic              rx_pe,
  output logic [15:0]       baud_div,
  output logic [4:0]        frame_cfg,
  output logic              irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  logic [7:0] idx;
  logic acc, wr, rd;
  logic s_txd, s_rxd, s_baud, s_ctrl;
  logic s_frm, s_stat, s_ints, s_lvl, s_bad;

  logic [15:0] baud_q;
  logic [4:0]  ctrl_q, frame_q, ints_q;
  logic        busy_q;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [TAW:0]   tx_cnt;
  logic [RAW:0]   rx_cnt;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, tx_flush;
  logic rx_push, rx_pop, rx_flush, rx_hit;
  logic [4:0] ints_set, ints_clr;
  logic [DATA_W-1:0] rx_head;
  logic [31:0] rdata;
  logic unused_bits;

  assign idx = pAddr[7:0];
  assign acc = pSel && pEnable;
  assign wr  = acc && pWrite;
  assign rd  = acc && !pWrite;

  assign s_txd  = idx == 8'h00;
  assign s_rxd  = idx == 8'h01;
  assign s_baud = idx == 8'h02;
  assign s_ctrl = idx == 8'h03;
  assign s_frm  = idx == 8'h04;
  assign s_stat = idx == 8'h05;
  assign s_ints = idx == 8'h06;
  assign s_lvl  = idx == 8'h07;
  assign s_bad  = idx > 8'h07;

  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == (TAW+1)'(TX_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign rx_full  = rx_cnt == (RAW+1)'(RX_DEPTH);

  assign tx_valid = ctrl_q[0] && !tx_empty;
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rp];
  assign rx_head  = rx_mem[rx_rp];

  assign tx_push  = wr && s_txd && !tx_full;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_flush = wr && s_ctrl && pWdata[5];
  assign rx_hit   = rx_valid && ctrl_q[1];
  assign rx_push  = rx_hit && !rx_full;
  assign rx_pop   = rd && s_rxd && !rx_empty;
  assign rx_flush = wr && s_ctrl && pWdata[6];

  assign ints_set = {rx_hit && rx_full, rx_hit && rx_pe,
                     rx_hit && rx_fe, rx_push, tx_done};
  assign ints_clr = (wr && s_ints) ? pWdata[4:0] : 5'b0;

  always_ff @(posedge pClk) begin
    if (tx_push) tx_mem[tx_wp] <= pWdata[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + (TAW+1)'(tx_push)
                       - (TAW+1)'(tx_pop);
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + (RAW+1)'(rx_push)
                       - (RAW+1)'(rx_pop);
    end
  end

  // busy tracks a frame handed to the serialiser but not yet done
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      baud_q  <= '0;
      ctrl_q  <= '0;
      frame_q <= '0;
      ints_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      if (wr && s_baud) baud_q  <= pWdata[15:0];
      if (wr && s_ctrl) ctrl_q  <= pWdata[4:0];
      if (wr && s_frm)  frame_q <= pWdata[4:0];
      ints_q <= (ints_q & ~ints_clr) | ints_set;
      if (tx_pop)       busy_q <= 1'b1;
      else if (tx_done) busy_q <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        s_rxd:  rdata = rx_empty ? '0 : 32'(rx_head);
        s_baud: rdata = {16'h0, baud_q};
        s_ctrl: rdata = {27'h0, ctrl_q};
        s_frm:  rdata = {27'h0, frame_q};
        s_stat: rdata = {27'h0, tx_empty && !busy_q,
                         rx_full, tx_full, tx_empty,
                         !rx_empty};
        s_ints: rdata = {27'h0, ints_q};
        s_lvl:  rdata = {8'h0, 8'(rx_cnt),
                         8'h0, 8'(tx_cnt)};
        default: rdata = '0;
      endcase
    end
  end

  assign pRData  = rdata;
  assign pSlvErr = acc && (s_bad
                   || (pWrite && s_txd && tx_full)
                   || (!pWrite && s_rxd && rx_empty));

  assign baud_div  = baud_q;
  assign frame_cfg = frame_q;
  assign irq = (ctrl_q[2] && ints_q[0])
            || (ctrl_q[3] && ints_q[1])
            || (ctrl_q[4] && |ints_q[4:2]);

  assign unused_bits = ^{pAddr[31:8], pWdata[31:16]};
endmodule

// File: tb/tb_uart_apb_regfile.sv
// Directed self-checking bench for uart_apb_regfile.
// One task per scenario, each with its own inline comparisons.
module tb_uart_apb_regfile;
  logic        pClk = 1'b0;
  logic        pReset = 1'b0;
  logic        pSel = 1'b0, pEnable = 1'b0, pWrite = 1'b0;
  logic [31:0] pAddr = '0, pWdata = '0;
  logic [31:0] pRData;
  logic        pSlvErr;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0, tx_done = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_fe = 1'b0, rx_pe = 1'b0;
  logic [15:0] baud_div;
  logic [4:0]  frame_cfg;
  logic        irq;

  int total = 0;
  int bad = 0;
  logic [31:0] rv;
  logic        ev;

  uart_apb_regfile #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .pClk(pClk), .pReset(pReset),
    .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite),
    .pAddr(pAddr), .pWdata(pWdata),
    .pRData(pRData), .pSlvErr(pSlvErr),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_done(tx_done),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_fe(rx_fe), .rx_pe(rx_pe),
    .baud_div(baud_div), .frame_cfg(frame_cfg),
    .irq(irq)
  );

  always #5 pClk = ~pClk;

  task automatic apb(input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic rxp,
                     output logic [31:0] r, output logic e);
    @(negedge pClk);
    pSel = 1'b1; pEnable = 1'b0; pWrite = w;
    pAddr = {24'h0, a}; pWdata = d;
    @(negedge pClk);
    pEnable = 1'b1;
    if (rxp) rx_valid = 1'b1;
    #1;
    r = pRData; e = pSlvErr;
    @(negedge pClk);
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    rx_valid = 1'b0;
    #1;
  endtask

  task automatic rx_pulse(input logic [7:0] d,
                          input logic fe, input logic pe);
    @(negedge pClk);
    rx_valid = 1'b1; rx_data = d; rx_fe = fe; rx_pe = pe;
    @(negedge pClk);
    rx_valid = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_v [8] = '{0, 0, 0, 0, 0, 32'h12, 0, 0};
    logic        exp_e [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    pReset = 1'b0;
    repeat (3) @(negedge pClk);
    #1;
    total++;
    if ({tx_valid, tx_data, baud_div, frame_cfg, irq, pSlvErr} !== '0
        || pRData !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    pReset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apb(1'b0, 8'(i), 32'h0, 1'b0, rv, ev);
      total++;
      if (rv !== exp_v[i] || ev !== exp_e[i]) begin
        bad++;
        $display("FAIL reset_read[%0d]: got %h err %b, required %h err %b",
                 i, rv, ev, exp_v[i], exp_e[i]);
      end
    end
    apb(1'b0, 8'h08, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0 || ev !== 1'b1) begin
      bad++;
      $display("FAIL bad_addr_read: got %h err %b, required 0 err 1", rv, ev);
    end
  endtask

  task automatic test_tx();
    apb(1'b1, 8'h03, 32'h05, 1'b0, rv, ev);
    apb(1'b1, 8'h00, 32'h41, 1'b0, rv, ev);
    apb(1'b1, 8'h00, 32'h42, 1'b0, rv, ev);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      bad++;
      $display("FAIL tx_head0: got v=%b d=%h, required v=1 d=41", tx_valid, tx_data);
    end
    apb(1'b0, 8'h07, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h2) begin
      bad++;
      $display("FAIL tx_level2: got %h, required 2", rv);
    end
    tx_ready = 1'b1;
    @(negedge pClk); #1;
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
      bad++;
      $display("FAIL tx_head1: got v=%b d=%h, required v=1 d=42", tx_valid, tx_data);
    end
    @(negedge pClk); #1;
    total++;
    if (tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL tx_drained: got v=%b, required 0", tx_valid);
    end
    tx_ready = 1'b0;
    apb(1'b0, 8'h07, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0) begin
      bad++;
      $display("FAIL tx_level0: got %h, required 0", rv);
    end
    apb(1'b0, 8'h05, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h02) begin
      bad++;
      $display("FAIL tx_busy_status: got %h, required 02", rv);
    end
    @(negedge pClk); tx_done = 1'b1;
    @(negedge pClk); tx_done = 1'b0;
    #1;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL txc_irq: got %b, required 1", irq);
    end
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h01) begin
      bad++;
      $display("FAIL txc_flag: got %h, required 01", rv);
    end
    apb(1'b0, 8'h05, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h12) begin
      bad++;
      $display("FAIL tx_idle_status: got %h, required 12", rv);
    end
    apb(1'b1, 8'h06, 32'h01, 1'b0, rv, ev);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL txc_w1c: irq got %b, required 0", irq);
    end
  endtask

  task automatic test_tx_full();
    apb(1'b1, 8'h03, 32'h00, 1'b0, rv, ev);
    for (int i = 0; i < 17; i++) begin
      apb(1'b1, 8'h00, 32'(i), 1'b0, rv, ev);
      total++;
      if (ev !== (i == 16)) begin
        bad++;
        $display("FAIL tx_push_err[%0d]: got %b, required %b", i, ev, i == 16);
      end
    end
    apb(1'b0, 8'h05, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h04) begin
      bad++;
      $display("FAIL tx_full_status: got %h, required 04", rv);
    end
    apb(1'b0, 8'h07, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h10 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL tx_full_level: got %h v=%b, required 10 v=0", rv, tx_valid);
    end
    apb(1'b1, 8'h03, 32'h01, 1'b0, rv, ev);
    total++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL txen_head: got v=%b d=%h, required v=1 d=00", tx_valid, tx_data);
    end
    apb(1'b1, 8'h03, 32'h21, 1'b0, rv, ev);
    apb(1'b0, 8'h07, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0 || tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL tx_flush: got %h v=%b, required 0 v=0", rv, tx_valid);
    end
    apb(1'b0, 8'h03, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h01) begin
      bad++;
      $display("FAIL ctrl_selfclear: got %h, required 01", rv);
    end
  endtask

  task automatic test_rx_overflow();
    apb(1'b1, 8'h03, 32'h00, 1'b0, rv, ev);
    rx_pulse(8'h77, 1'b1, 1'b1);
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0) begin
      bad++;
      $display("FAIL rx_disabled_flags: got %h, required 0", rv);
    end
    apb(1'b1, 8'h03, 32'h0A, 1'b0, rv, ev);
    for (int i = 0; i < 17; i++) rx_pulse(8'(i), 1'b0, 1'b0);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL rxc_irq: got %b, required 1", irq);
    end
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h12) begin
      bad++;
      $display("FAIL rx_ovr_flags: got %h, required 12", rv);
    end
    apb(1'b0, 8'h07, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0010_0000) begin
      bad++;
      $display("FAIL rx_level16: got %h, required 00100000", rv);
    end
    apb(1'b0, 8'h05, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h1B) begin
      bad++;
      $display("FAIL rx_full_status: got %h, required 1b", rv);
    end
    for (int i = 0; i < 17; i++) begin
      apb(1'b0, 8'h01, 32'h0, 1'b0, rv, ev);
      total++;
      if (rv !== (i < 16 ? 32'(i) : 32'h0) || ev !== (i == 16)) begin
        bad++;
        $display("FAIL rx_read[%0d]: got %h err %b", i, rv, ev);
      end
    end
    apb(1'b1, 8'h06, 32'h1F, 1'b0, rv, ev);
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL rx_w1c_all: got %h irq %b, required 0 irq 0", rv, irq);
    end
  endtask

  task automatic test_rx_errors();
    apb(1'b1, 8'h03, 32'h12, 1'b0, rv, ev);
    rx_pulse(8'h55, 1'b1, 1'b0);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL fe_irq: got %b, required 1", irq);
    end
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h06) begin
      bad++;
      $display("FAIL fe_flag: got %h, required 06", rv);
    end
    rx_data = 8'h56; rx_fe = 1'b1;
    apb(1'b1, 8'h06, 32'h04, 1'b1, rv, ev);
    rx_fe = 1'b0;
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h06) begin
      bad++;
      $display("FAIL fe_set_wins: got %h, required 06", rv);
    end
    apb(1'b1, 8'h06, 32'h1F, 1'b0, rv, ev);
    rx_pulse(8'h57, 1'b0, 1'b1);
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0A || irq !== 1'b1) begin
      bad++;
      $display("FAIL pe_flag: got %h irq %b, required 0a irq 1", rv, irq);
    end
    apb(1'b1, 8'h06, 32'h1F, 1'b0, rv, ev);
  endtask

  task automatic test_rx_flush();
    for (int i = 0; i < 5; i++) rx_pulse(8'(8'h60 + i), 1'b0, 1'b0);
    apb(1'b0, 8'h07, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0008_0000) begin
      bad++;
      $display("FAIL rx_half_level: got %h, required 00080000", rv);
    end
    rx_data = 8'h99;
    apb(1'b1, 8'h03, 32'h42, 1'b1, rv, ev);
    apb(1'b0, 8'h07, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0) begin
      bad++;
      $display("FAIL rx_flush_level: got %h, required 0", rv);
    end
    apb(1'b0, 8'h05, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h12) begin
      bad++;
      $display("FAIL rx_flush_status: got %h, required 12", rv);
    end
    apb(1'b0, 8'h03, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h02) begin
      bad++;
      $display("FAIL rx_flush_ctrl: got %h, required 02", rv);
    end
  endtask

  task automatic test_regs();
    apb(1'b1, 8'h02, 32'h1234_ABCD, 1'b0, rv, ev);
    apb(1'b0, 8'h02, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'hABCD || baud_div !== 16'hABCD) begin
      bad++;
      $display("FAIL baud: got %h out %h, required abcd", rv, baud_div);
    end
    apb(1'b1, 8'h04, 32'hFFFF_FFFF, 1'b0, rv, ev);
    apb(1'b0, 8'h04, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h1F || frame_cfg !== 5'h1F) begin
      bad++;
      $display("FAIL frame: got %h out %h, required 1f", rv, frame_cfg);
    end
    apb(1'b1, 8'h20, 32'hFFFF_FFFF, 1'b0, rv, ev);
    total++;
    if (ev !== 1'b1) begin
      bad++;
      $display("FAIL bad_addr_write: err got %b, required 1", ev);
    end
    apb(1'b0, 8'h00, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0 || ev !== 1'b0 || pRData !== 32'h0) begin
      bad++;
      $display("FAIL txdata_read: got %h err %b idle %h", rv, ev, pRData);
    end
  endtask

  task automatic test_reset_mid();
    apb(1'b1, 8'h03, 32'h01, 1'b0, rv, ev);
    apb(1'b1, 8'h00, 32'h33, 1'b0, rv, ev);
    tx_ready = 1'b1;
    @(negedge pClk);
    tx_ready = 1'b0;
    pReset = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || baud_div !== 16'h0 || frame_cfg !== 5'h0) begin
      bad++;
      $display("FAIL reset_async: v=%b baud=%h frame=%h, required 0",
               tx_valid, baud_div, frame_cfg);
    end
    @(negedge pClk);
    pReset = 1'b1;
    apb(1'b0, 8'h05, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h12) begin
      bad++;
      $display("FAIL reset_mid_status: got %h, required 12", rv);
    end
    apb(1'b0, 8'h06, 32'h0, 1'b0, rv, ev);
    total++;
    if (rv !== 32'h0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_flags: got %h irq %b, required 0", rv, irq);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_tx_full();
    test_rx_overflow();
    test_rx_errors();
    test_rx_flush();
    test_regs();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
